// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants for the 5-stage MIPS pipeline
package mips_pkg;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - owns PC, instruction-memory handshake, IF/ID register and redirect flush flags
// Ports:
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   stallD                            decode stall: IF/ID and PC frozen, redirects ignored
//   branchTakenD, branchTargetD       taken-branch redirect from decode
//   imemReq, imemAddr                 fetch request / word-aligned address (always the PC)
//   imemGnt, imemRvalid, imemRdata    memory grant, read-data valid, instruction word
//   instcodeD, pcPlus4D, validD       IF/ID register contents
//   PCSelectD, PCSelectE              one-cycle redirect flush flags for decode / execute
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallD,
   input  logic        branchTakenD,
   input  logic [31:0] branchTargetD,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemGnt,
   input  logic        imemRvalid,
   input  logic [31:0] imemRdata,
   output logic [31:0] instcodeD,
   output logic [31:0] pcPlus4D,
   output logic        validD,
   output logic        PCSelectD,
   output logic        PCSelectE
);
   fetch_state_t r_state, w_state_nx;
   logic [31:0]  r_pc, r_req_pc, r_hold, r_instr, r_pc4;
   logic         r_valid, r_pcsel_d, r_pcsel_e;
   logic         w_redirect, w_load;
   logic [31:0]  w_instr_in;
   // A redirect needs a real instruction in decode and an unstalled pipe.
   assign w_redirect = branchTakenD & r_valid & ~stallD;
   // Redirect wins over any instruction arriving in the same cycle.
   assign w_load     = ((r_state == S_WAIT && imemRvalid) || r_state == S_HOLD) && !stallD && !w_redirect;
   assign w_instr_in = (r_state == S_HOLD) ? r_hold : imemRdata;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = S_REQ;
         S_REQ:   if (imemGnt) w_state_nx = w_redirect ? S_DROP : S_WAIT;
         // In-flight data is dropped if the redirect lands before it returns.
         S_WAIT:  if (w_redirect) w_state_nx = imemRvalid ? S_REQ : S_DROP;
                  else if (imemRvalid) w_state_nx = stallD ? S_HOLD : S_REQ;
         S_HOLD:  if (!stallD) w_state_nx = S_REQ;
         S_DROP:  if (imemRvalid) w_state_nx = S_REQ;
         default: w_state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_req_pc  <= RESET_PC;
         r_hold    <= '0;
         r_instr   <= NOP_INSTR;
         r_pc4     <= '0;
         r_valid   <= 1'b0;
         r_pcsel_d <= 1'b0;
         r_pcsel_e <= 1'b0;
      end else begin
         r_pcsel_d <= w_redirect;
         r_pcsel_e <= r_pcsel_d;
         if (r_state == S_REQ && imemGnt) r_req_pc <= r_pc;
         if (r_state == S_WAIT && imemRvalid && stallD) r_hold <= imemRdata;
         r_pc <= w_redirect ? {branchTargetD[31:2], 2'b00} : w_load ? r_pc + 32'd4 : r_pc;
         if (!stallD) begin
            r_instr <= w_load ? w_instr_in : NOP_INSTR;
            r_valid <= w_load;
            if (w_load) r_pc4 <= r_req_pc + 32'd4;
         end
      end
   end
   assign imemReq   = (r_state == S_REQ);
   assign imemAddr  = r_pc;
   assign instcodeD = r_instr;
   assign pcPlus4D  = r_pc4;
   assign validD    = r_valid;
   assign PCSelectD = r_pcsel_d;
   assign PCSelectE = r_pcsel_e;
endmodule
